// File: rtl/cpu_pkg.sv
// Shared fetch-side constants and the fetch FSM state type.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT = 32'h0000_6FFC;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fsm_t;

endpackage

// File: rtl/npc_sel.sv
// Next-PC priority mux for the fetch stage: halt, live redirect, pending redirect, sequential.
module npc_sel (
  input  logic        run,
  input  logic        halt,
  input  logic        d_redirect,
  input  logic [31:0] d_npc,
  input  logic        pend,
  input  logic [31:0] pend_npc,
  input  logic [31:0] pc,
  output logic [31:0] pc_nxt,
  output logic        pend_nxt,
  output logic [31:0] pend_npc_nxt
);

  // Everything holds unless running; halt parks a redirect in the one-deep slot.
  always_comb begin
    pc_nxt       = pc;
    pend_nxt     = pend;
    pend_npc_nxt = pend_npc;
    if (run) begin
      if (halt) begin
        if (d_redirect) begin
          pend_nxt     = 1'b1;
          pend_npc_nxt = d_npc;
        end
      end else if (d_redirect) begin
        pc_nxt   = d_npc;
        pend_nxt = 1'b0;
      end else if (pend) begin
        pc_nxt   = pend_npc;
        pend_nxt = 1'b0;
      end else begin
        pc_nxt = pc + 32'd4;
      end
    end
  end

endmodule

// File: rtl/f_stage.sv
// Fetch stage: owns the PC, drives the instruction-memory address and presents
// the fetched instruction to the F/D register. Redirects raised under halt are
// held in a pending slot and applied once the stall clears.
module f_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] IM_BASE  = cpu_pkg::IM_BASE,
  parameter logic [31:0] IM_LIMIT = cpu_pkg::IM_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic        d_redirect,
  input  logic [31:0] d_npc,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_new_instr,
  output logic        f_addr_err
);

  fsm_t        state_q;
  fsm_t        state_d;
  logic [31:0] pc;
  logic        pend;
  logic [31:0] pend_npc;
  logic [31:0] pc_nxt;
  logic        pend_nxt;
  logic [31:0] pend_npc_nxt;
  logic        run;
  logic        fetch_ok;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < IM_BASE) || (a > IM_LIMIT);
  endfunction

  assign run = (state_q == RUN);

  npc_sel u_npc_sel (
    .run          (run),
    .halt         (halt),
    .d_redirect   (d_redirect),
    .d_npc        (d_npc),
    .pend         (pend),
    .pend_npc     (pend_npc),
    .pc           (pc),
    .pc_nxt       (pc_nxt),
    .pend_nxt     (pend_nxt),
    .pend_npc_nxt (pend_npc_nxt)
  );

  // FSM register: BOOT after reset, then RUN.
  always_ff @(posedge clk) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // BOOT lasts exactly one cycle regardless of halt; RUN is terminal.
  always_comb begin
    state_d = state_q;
    if (state_q == BOOT) state_d = RUN;
  end

  // PC and pending-redirect slot; reset discards any parked redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      pend     <= 1'b0;
      pend_npc <= 32'h0;
    end else begin
      pc       <= pc_nxt;
      pend     <= pend_nxt;
      pend_npc <= pend_npc_nxt;
    end
  end

  // Zero-latency fetch: outputs are combinational in pc and the memory read data.
  always_comb begin
    f_addr_err  = addr_bad(pc);
    fetch_ok    = run && !f_addr_err;
    i_inst_addr = pc;
    f_pc        = pc;
    f_new_instr = fetch_ok;
    f_instr     = fetch_ok ? i_inst_rdata : NOP;
  end

endmodule

// File: tb/tb_f_stage.sv
// Directed bench for f_stage: reset release, stall, redirect, pending redirect,
// address errors, PC wrap and reset during a pending redirect.
module tb_f_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0;
  logic        d_redirect = 1'b0;
  logic [31:0] d_npc = 32'h0;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_new_instr;
  logic        f_addr_err;

  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'h0;

  int tests_run = 0;
  int tests_failed = 0;

  f_stage dut (
    .clk          (clk),
    .reset        (reset),
    .halt         (halt),
    .d_redirect   (d_redirect),
    .d_npc        (d_npc),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .f_pc         (f_pc),
    .f_instr      (f_instr),
    .f_new_instr  (f_new_instr),
    .f_addr_err   (f_addr_err)
  );

  always #5 clk = ~clk;

  // Memory model: word = address ^ A5A5_0000, unless overridden.
  always_comb i_inst_rdata = ovr_en ? ovr_val : (i_inst_addr ^ 32'hA5A5_0000);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests_run++;
    if (f_pc !== 32'h3000) begin tests_failed++; $display("FAIL reset_pc got %h exp %h", f_pc, 32'h3000); end
    tests_run++;
    if (f_new_instr !== 1'b0 || f_instr !== 32'h0 || f_addr_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_outs got new=%b instr=%h err=%b exp 0/0/0", f_new_instr, f_instr, f_addr_err);
    end
    reset = 1'b0;
    step();
    tests_run++;
    if (f_pc !== 32'h3000 || f_new_instr !== 1'b1 || f_instr !== 32'hA5A5_3000) begin
      tests_failed++; $display("FAIL first_fetch got pc=%h new=%b instr=%h exp 3000/1/a5a53000", f_pc, f_new_instr, f_instr);
    end
    step();
    tests_run++;
    if (f_pc !== 32'h3004) begin tests_failed++; $display("FAIL seq_3004 got %h exp %h", f_pc, 32'h3004); end
    step();
    tests_run++;
    if (f_pc !== 32'h3008 || f_instr !== 32'hA5A5_3008) begin
      tests_failed++; $display("FAIL seq_3008 got pc=%h instr=%h exp 3008/a5a53008", f_pc, f_instr);
    end
  endtask

  task automatic test_stall();
    logic [31:0] vals [3];
    vals[0] = 32'h1111_0001;
    vals[1] = 32'h2222_0002;
    vals[2] = 32'h3333_0003;
    halt = 1'b1;
    ovr_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      ovr_val = vals[k];
      #1;
      tests_run++;
      if (f_pc !== 32'h3008 || f_instr !== vals[k] || f_new_instr !== 1'b1) begin
        tests_failed++; $display("FAIL stall_%0d got pc=%h instr=%h new=%b exp 3008/%h/1", k, f_pc, f_instr, f_new_instr, vals[k]);
      end
    end
    ovr_en = 1'b0;
    halt = 1'b0;
    step();
    tests_run++;
    if (f_pc !== 32'h300C) begin tests_failed++; $display("FAIL stall_release got %h exp %h", f_pc, 32'h300C); end
    step();
  endtask

  task automatic test_redirect();
    tests_run++;
    if (f_pc !== 32'h3010) begin tests_failed++; $display("FAIL redir_pre got %h exp %h", f_pc, 32'h3010); end
    d_redirect = 1'b1;
    d_npc = 32'h3100;
    step();
    d_redirect = 1'b0;
    tests_run++;
    if (f_pc !== 32'h3100 || f_instr !== 32'hA5A5_3100) begin
      tests_failed++; $display("FAIL redir_target got pc=%h instr=%h exp 3100/a5a53100", f_pc, f_instr);
    end
    step();
    tests_run++;
    if (f_pc !== 32'h3104) begin tests_failed++; $display("FAIL redir_next got %h exp %h", f_pc, 32'h3104); end
  endtask

  task automatic test_pending();
    halt = 1'b1; d_redirect = 1'b1; d_npc = 32'h3200;
    step();
    d_redirect = 1'b0;
    tests_run++;
    if (f_pc !== 32'h3104) begin tests_failed++; $display("FAIL pend_hold1 got %h exp %h", f_pc, 32'h3104); end
    step();
    tests_run++;
    if (f_pc !== 32'h3104) begin tests_failed++; $display("FAIL pend_hold2 got %h exp %h", f_pc, 32'h3104); end
    halt = 1'b0;
    step();
    tests_run++;
    if (f_pc !== 32'h3200) begin tests_failed++; $display("FAIL pend_apply got %h exp %h", f_pc, 32'h3200); end
    step();
    tests_run++;
    if (f_pc !== 32'h3204) begin tests_failed++; $display("FAIL pend_cleared got %h exp %h", f_pc, 32'h3204); end
    // Overwrite the slot while halted, then a live redirect as halt falls.
    halt = 1'b1; d_redirect = 1'b1; d_npc = 32'h3200;
    step();
    d_npc = 32'h3280;
    step();
    d_redirect = 1'b0;
    step();
    tests_run++;
    if (f_pc !== 32'h3204) begin tests_failed++; $display("FAIL pend_hold3 got %h exp %h", f_pc, 32'h3204); end
    halt = 1'b0; d_redirect = 1'b1; d_npc = 32'h3300;
    step();
    d_redirect = 1'b0;
    tests_run++;
    if (f_pc !== 32'h3300) begin tests_failed++; $display("FAIL live_beats_pend got %h exp %h", f_pc, 32'h3300); end
    step();
    tests_run++;
    if (f_pc !== 32'h3304) begin tests_failed++; $display("FAIL live_clears_pend got %h exp %h", f_pc, 32'h3304); end
    // Overwritten slot: 3280 must win over the earlier 3200.
    halt = 1'b1; d_redirect = 1'b1; d_npc = 32'h3200;
    step();
    d_npc = 32'h3280;
    step();
    d_redirect = 1'b0; halt = 1'b0;
    step();
    tests_run++;
    if (f_pc !== 32'h3280) begin tests_failed++; $display("FAIL pend_overwrite got %h exp %h", f_pc, 32'h3280); end
  endtask

  task automatic test_addr_err();
    d_redirect = 1'b1; d_npc = 32'h3002;
    step();
    d_redirect = 1'b0;
    tests_run++;
    if (f_pc !== 32'h3002 || f_addr_err !== 1'b1 || f_instr !== 32'h0 || f_new_instr !== 1'b0) begin
      tests_failed++; $display("FAIL err_misal got pc=%h err=%b instr=%h new=%b exp 3002/1/0/0", f_pc, f_addr_err, f_instr, f_new_instr);
    end
    step();
    tests_run++;
    if (f_pc !== 32'h3006 || f_addr_err !== 1'b1) begin
      tests_failed++; $display("FAIL err_misal_next got pc=%h err=%b exp 3006/1", f_pc, f_addr_err);
    end
    d_redirect = 1'b1; d_npc = 32'h6FFC;
    step();
    d_redirect = 1'b0;
    tests_run++;
    if (f_pc !== 32'h6FFC || f_addr_err !== 1'b0 || f_new_instr !== 1'b1 || f_instr !== 32'hA5A5_6FFC) begin
      tests_failed++; $display("FAIL err_limit_ok got pc=%h err=%b new=%b instr=%h exp 6ffc/0/1/a5a56ffc", f_pc, f_addr_err, f_new_instr, f_instr);
    end
    step();
    tests_run++;
    if (f_pc !== 32'h7000 || f_addr_err !== 1'b1 || f_instr !== 32'h0 || f_new_instr !== 1'b0) begin
      tests_failed++; $display("FAIL err_over got pc=%h err=%b instr=%h new=%b exp 7000/1/0/0", f_pc, f_addr_err, f_instr, f_new_instr);
    end
    step();
    tests_run++;
    if (f_pc !== 32'h7004 || f_addr_err !== 1'b1) begin
      tests_failed++; $display("FAIL err_over_next got pc=%h err=%b exp 7004/1", f_pc, f_addr_err);
    end
    d_redirect = 1'b1; d_npc = 32'h2FFC;
    step();
    tests_run++;
    if (f_pc !== 32'h2FFC || f_addr_err !== 1'b1) begin
      tests_failed++; $display("FAIL err_under got pc=%h err=%b exp 2ffc/1", f_pc, f_addr_err);
    end
    d_npc = 32'hFFFF_FFFC;
    step();
    d_redirect = 1'b0;
    step();
    tests_run++;
    if (f_pc !== 32'h0 || f_addr_err !== 1'b1) begin
      tests_failed++; $display("FAIL wrap got pc=%h err=%b exp 0/1", f_pc, f_addr_err);
    end
    d_redirect = 1'b1; d_npc = 32'h3000;
    step();
    d_redirect = 1'b0;
    tests_run++;
    if (f_pc !== 32'h3000 || f_addr_err !== 1'b0 || f_new_instr !== 1'b1) begin
      tests_failed++; $display("FAIL err_recover got pc=%h err=%b new=%b exp 3000/0/1", f_pc, f_addr_err, f_new_instr);
    end
  endtask

  task automatic test_reset_mid();
    step();
    halt = 1'b1; d_redirect = 1'b1; d_npc = 32'h3400;
    step();
    d_redirect = 1'b0;
    step();
    tests_run++;
    if (f_pc !== 32'h3004) begin tests_failed++; $display("FAIL mid_hold got %h exp %h", f_pc, 32'h3004); end
    reset = 1'b1;
    step();
    tests_run++;
    if (f_pc !== 32'h3000 || f_new_instr !== 1'b0 || f_instr !== 32'h0) begin
      tests_failed++; $display("FAIL mid_reset got pc=%h new=%b instr=%h exp 3000/0/0", f_pc, f_new_instr, f_instr);
    end
    reset = 1'b0;
    step();
    tests_run++;
    if (f_pc !== 32'h3000 || f_new_instr !== 1'b1) begin
      tests_failed++; $display("FAIL boot_ignores_halt got pc=%h new=%b exp 3000/1", f_pc, f_new_instr);
    end
    halt = 1'b0;
    step();
    tests_run++;
    if (f_pc !== 32'h3004) begin tests_failed++; $display("FAIL pend_dropped got %h exp %h", f_pc, 32'h3004); end
    step();
    tests_run++;
    if (f_pc !== 32'h3008) begin tests_failed++; $display("FAIL post_reset_seq got %h exp %h", f_pc, 32'h3008); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_pending();
    test_addr_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
